// File: rtl/alu_pkg.sv
// Shared constants for the ALU op issuer: op codes, funct codes, FSM states and R-type fields.
package alu_pkg;

   localparam logic [2:0] OpAnd = 3'b000;
   localparam logic [2:0] OpOr  = 3'b001;
   localparam logic [2:0] OpAdd = 3'b010;
   localparam logic [2:0] OpSub = 3'b110;
   localparam logic [2:0] OpSlt = 3'b011;

   localparam logic [5:0] FnAnd = 6'h24;
   localparam logic [5:0] FnOr  = 6'h25;
   localparam logic [5:0] FnAdd = 6'h20;
   localparam logic [5:0] FnSub = 6'h22;
   localparam logic [5:0] FnSlt = 6'h2A;

   localparam int unsigned OpcMsb = 31;
   localparam int unsigned OpcLsb = 26;
   localparam int unsigned RsMsb  = 25;
   localparam int unsigned RsLsb  = 21;
   localparam int unsigned RtMsb  = 20;
   localparam int unsigned RtLsb  = 16;
   localparam int unsigned RdMsb  = 15;
   localparam int unsigned RdLsb  = 11;
   localparam int unsigned FnMsb  = 5;
   localparam int unsigned FnLsb  = 0;

   typedef enum logic [1:0] {
      StIdle,
      StOprd,
      StExec,
      StResp
   } state_e;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational R-type decode: {opcode, funct} to ALU op code plus a legality flag.
module alu_funct_decode
   import alu_pkg::*;
(
   input  logic [5:0] opcode_i,
   input  logic [5:0] funct_i,
   output logic [2:0] op_o,
   output logic       legal_o
);

   always_comb begin
      op_o    = OpAnd;
      legal_o = 1'b0;
      if (opcode_i == 6'd0) begin
         legal_o = 1'b1;
         case (funct_i)
            FnAnd:   op_o = OpAnd;
            FnOr:    op_o = OpOr;
            FnAdd:   op_o = OpAdd;
            FnSub:   op_o = OpSub;
            FnSlt:   op_o = OpSlt;
            default: legal_o = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/alu_op_issuer.sv
// Multi-cycle R-type issuer driving an external combinational ALU.
// Define TRAP_ON_OVF_EN to trap signed overflow on ADD/SUB (no writeback, resp_err set).
module alu_op_issuer
   import alu_pkg::*;
#(
   parameter int unsigned NREGS = 32,
   parameter int unsigned XLEN  = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cfg_we_i,
   input  logic [4:0]      cfg_addr_i,
   input  logic [XLEN-1:0] cfg_wdata_i,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [31:0]     req_instr_i,
   output logic [XLEN-1:0] alu_a_o,
   output logic [XLEN-1:0] alu_b_o,
   output logic [2:0]      alu_op_o,
   input  logic [XLEN-1:0] alu_out_i,
   input  logic            alu_over_i,
   output logic            resp_valid_o,
   input  logic            resp_ready_i,
   output logic [4:0]      resp_rd_o,
   output logic [XLEN-1:0] resp_result_o,
   output logic            resp_zero_o,
   output logic            resp_over_o,
   output logic            resp_err_o
);

   state_e          state_q;
   logic            ready_q;
   logic [5:0]      opc_q;
   logic [4:0]      rs_q;
   logic [4:0]      rt_q;
   logic [4:0]      rd_q;
   logic [5:0]      fn_q;
   logic [XLEN-1:0] alu_a_q;
   logic [XLEN-1:0] alu_b_q;
   logic [2:0]      alu_op_q;
   logic            resp_valid_q;
   logic [4:0]      resp_rd_q;
   logic [XLEN-1:0] resp_result_q;
   logic            resp_zero_q;
   logic            resp_over_q;
   logic            resp_err_q;
   logic [XLEN-1:0] rf_q [NREGS];

   logic [2:0] dec_op;
   logic       dec_legal;
   logic       accept;
   logic       trap;
   logic       unused_shamt;

   assign unused_shamt = ^req_instr_i[10:6];

   alu_funct_decode u_decode (
      .opcode_i (opc_q),
      .funct_i  (fn_q),
      .op_o     (dec_op),
      .legal_o  (dec_legal)
   );

   // ready_q is low for the first cycle after reset so req_ready stays 0 until a clock arrives.
   assign req_ready_o = ready_q & ~cfg_we_i;
   assign accept      = req_valid_i & req_ready_o;

`ifdef TRAP_ON_OVF_EN
   assign trap = alu_over_i & ((alu_op_q == OpAdd) | (alu_op_q == OpSub));
`else
   assign trap = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         ready_q       <= 1'b0;
         opc_q         <= '0;
         rs_q          <= '0;
         rt_q          <= '0;
         rd_q          <= '0;
         fn_q          <= '0;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         alu_op_q      <= '0;
         resp_valid_q  <= 1'b0;
         resp_rd_q     <= '0;
         resp_result_q <= '0;
         resp_zero_q   <= 1'b0;
         resp_over_q   <= 1'b0;
         resp_err_q    <= 1'b0;
         for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (cfg_we_i) begin
                  if (cfg_addr_i != 5'd0) rf_q[cfg_addr_i] <= cfg_wdata_i;
                  ready_q <= 1'b1;
               end else if (accept) begin
                  opc_q   <= req_instr_i[OpcMsb:OpcLsb];
                  rs_q    <= req_instr_i[RsMsb:RsLsb];
                  rt_q    <= req_instr_i[RtMsb:RtLsb];
                  rd_q    <= req_instr_i[RdMsb:RdLsb];
                  fn_q    <= req_instr_i[FnMsb:FnLsb];
                  ready_q <= 1'b0;
                  state_q <= StOprd;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            StOprd: begin
               if (dec_legal) begin
                  alu_a_q  <= rf_q[rs_q];
                  alu_b_q  <= rf_q[rt_q];
                  alu_op_q <= dec_op;
                  state_q  <= StExec;
               end else begin
                  resp_err_q    <= 1'b1;
                  resp_result_q <= '0;
                  resp_over_q   <= 1'b0;
                  resp_zero_q   <= 1'b1;
                  resp_rd_q     <= rd_q;
                  resp_valid_q  <= 1'b1;
                  state_q       <= StResp;
               end
            end
            StExec: begin
               resp_result_q <= alu_out_i;
               resp_over_q   <= alu_over_i;
               resp_zero_q   <= (alu_out_i == '0);
               resp_err_q    <= trap;
               resp_rd_q     <= rd_q;
               resp_valid_q  <= 1'b1;
               if ((rd_q != 5'd0) && !trap) rf_q[rd_q] <= alu_out_i;
               state_q       <= StResp;
            end
            StResp: begin
               if (resp_ready_i) begin
                  resp_valid_q <= 1'b0;
                  ready_q      <= 1'b1;
                  state_q      <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign alu_a_o       = alu_a_q;
   assign alu_b_o       = alu_b_q;
   assign alu_op_o      = alu_op_q;
   assign resp_valid_o  = resp_valid_q;
   assign resp_rd_o     = resp_rd_q;
   assign resp_result_o = resp_result_q;
   assign resp_zero_o   = resp_zero_q;
   assign resp_over_o   = resp_over_q;
   assign resp_err_o    = resp_err_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer with a behavioural 32-bit ALU attached to its datapath ports.
module tb_alu_op_issuer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_we = 1'b0;
   logic [4:0]  cfg_addr = '0;
   logic [31:0] cfg_wdata = '0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_instr = '0;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [2:0]  alu_op;
   logic [31:0] alu_out;
   logic        alu_over;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [4:0]  resp_rd;
   logic [31:0] resp_result;
   logic        resp_zero;
   logic        resp_over;
   logic        resp_err;

   int checks = 0;
   int errors = 0;
   int lat;
   logic [31:0] held;

   always #5 clk = ~clk;

   alu_op_issuer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cfg_we_i      (cfg_we),
      .cfg_addr_i    (cfg_addr),
      .cfg_wdata_i   (cfg_wdata),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready),
      .req_instr_i   (req_instr),
      .alu_a_o       (alu_a),
      .alu_b_o       (alu_b),
      .alu_op_o      (alu_op),
      .alu_out_i     (alu_out),
      .alu_over_i    (alu_over),
      .resp_valid_o  (resp_valid),
      .resp_ready_i  (resp_ready),
      .resp_rd_o     (resp_rd),
      .resp_result_o (resp_result),
      .resp_zero_o   (resp_zero),
      .resp_over_o   (resp_over),
      .resp_err_o    (resp_err)
   );

   // Stand-in for the completeALU datapath.
   always_comb begin
      alu_out  = '0;
      alu_over = 1'b0;
      case (alu_op)
         3'b000: alu_out = alu_a & alu_b;
         3'b001: alu_out = alu_a | alu_b;
         3'b010: begin
            alu_out  = alu_a + alu_b;
            alu_over = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
         end
         3'b110: begin
            alu_out  = alu_a - alu_b;
            alu_over = (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]);
         end
         3'b011: alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
         default: alu_out = '0;
      endcase
   end

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'd0, rs, rt, rd, 5'd0, fn};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic cfg_write(input logic [4:0] addr, input logic [31:0] data);
      @(negedge clk);
      cfg_we    = 1'b1;
      cfg_addr  = addr;
      cfg_wdata = data;
      @(negedge clk);
      cfg_we    = 1'b0;
   endtask

   // Present a request, wait for acceptance, then count cycles until resp_valid.
   task automatic send(input logic [31:0] instr, output int l);
      int n;
      @(negedge clk);
      req_valid = 1'b1;
      req_instr = instr;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("accept_in_time", 32'(n < 20), 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      l = 0;
      do begin
         @(negedge clk);
         l++;
      end while (!resp_valid && l < 20);
   endtask

   task automatic ack();
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      @(negedge clk);
      chk("req_ready_after_resp", 32'(req_ready), 32'd1);
   endtask

   task automatic run(input string name, input logic [31:0] instr, input int lat_exp,
                      input logic [4:0] rd, input logic [31:0] res, input logic zero,
                      input logic over, input logic err);
      int l;
      send(instr, l);
      chk({name, "_latency"}, 32'(l), 32'(lat_exp));
      chk({name, "_valid"}, 32'(resp_valid), 32'd1);
      chk({name, "_rd"}, 32'(resp_rd), 32'(rd));
      chk({name, "_result"}, resp_result, res);
      chk({name, "_zero"}, 32'(resp_zero), 32'(zero));
      chk({name, "_over"}, 32'(resp_over), 32'(over));
      chk({name, "_err"}, 32'(resp_err), 32'(err));
      ack();
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_op", 32'(alu_op), 32'd0);
      chk("rst_resp_zero", 32'(resp_zero), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("rst_release_ready_low", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("rst_release_ready_high", 32'(req_ready), 32'd1);

      // ADD then OR read-back of r3
      cfg_write(5'd1, 32'd25);
      cfg_write(5'd2, 32'd23);
      run("add", 32'h0022_1820, 3, 5'd3, 32'd48, 1'b0, 1'b0, 1'b0);
      chk("add_alu_op", 32'(alu_op), 32'b010);
      chk("add_alu_a", alu_a, 32'd25);
      chk("add_alu_b", alu_b, 32'd23);
      run("or_r3", rtype(5'd3, 5'd0, 5'd9, 6'h25), 3, 5'd9, 32'd48, 1'b0, 1'b0, 1'b0);
      chk("or_alu_op", 32'(alu_op), 32'b001);
      chk("or_r0_reads_zero", alu_b, 32'd0);

      // SUB and SLT
      cfg_write(5'd1, 32'd1);
      cfg_write(5'd4, 32'd34);
      run("sub", rtype(5'd1, 5'd4, 5'd5, 6'h22), 3, 5'd5, 32'hFFFF_FFDF, 1'b0, 1'b0, 1'b0);
      chk("sub_alu_op", 32'(alu_op), 32'b110);
      cfg_write(5'd7, 32'd555);
      cfg_write(5'd8, 32'd555);
      run("slt", rtype(5'd7, 5'd8, 5'd6, 6'h2A), 3, 5'd6, 32'd0, 1'b1, 1'b0, 1'b0);
      chk("slt_alu_op", 32'(alu_op), 32'b011);

      // Signed overflow on ADD
      cfg_write(5'd10, 32'h7FFF_FFFF);
      cfg_write(5'd11, 32'd1);
`ifdef TRAP_ON_OVF_EN
      run("ovf_add", rtype(5'd10, 5'd11, 5'd12, 6'h20), 3, 5'd12, 32'h8000_0000, 1'b0, 1'b1,
          1'b1);
      run("ovf_readback", rtype(5'd12, 5'd0, 5'd13, 6'h25), 3, 5'd13, 32'd0, 1'b1, 1'b0, 1'b0);
`else
      run("ovf_add", rtype(5'd10, 5'd11, 5'd12, 6'h20), 3, 5'd12, 32'h8000_0000, 1'b0, 1'b1,
          1'b0);
      run("ovf_readback", rtype(5'd12, 5'd0, 5'd13, 6'h25), 3, 5'd13, 32'h8000_0000, 1'b0, 1'b0,
          1'b0);
`endif
      held = alu_a;

      // Illegal funct and illegal opcode, both aimed at r3 (holds 48)
      run("ill_funct", rtype(5'd1, 5'd2, 5'd3, 6'h08), 2, 5'd3, 32'd0, 1'b1, 1'b0, 1'b1);
      chk("ill_funct_alu_op", 32'(alu_op), 32'b001);
      chk("ill_funct_alu_a", alu_a, held);
      chk("ill_funct_alu_b", alu_b, 32'd0);
      run("ill_opc", {6'h23, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 2, 5'd3, 32'd0, 1'b1, 1'b0, 1'b1);
      chk("ill_opc_alu_op", 32'(alu_op), 32'b001);
      run("ill_no_wb", rtype(5'd3, 5'd0, 5'd14, 6'h25), 3, 5'd14, 32'd48, 1'b0, 1'b0, 1'b0);

      // Response backpressure for 5 cycles
      send(rtype(5'd4, 5'd1, 5'd15, 6'h20), lat);
      chk("bp_latency", 32'(lat), 32'd3);
      held = resp_result;
      chk("bp_result", held, 32'd35);
      req_valid = 1'b1;
      req_instr = rtype(5'd1, 5'd1, 5'd16, 6'h20);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid_held", 32'(resp_valid), 32'd1);
         chk("bp_result_held", resp_result, held);
         chk("bp_rd_held", 32'(resp_rd), 32'd15);
         chk("bp_req_ready_low", 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      ack();

      // cfg_we has priority over a simultaneous request
      @(negedge clk);
      cfg_we    = 1'b1;
      cfg_addr  = 5'd20;
      cfg_wdata = 32'h0000_1234;
      req_valid = 1'b1;
      req_instr = rtype(5'd20, 5'd0, 5'd21, 6'h25);
      #1 chk("prio_req_ready_low", 32'(req_ready), 32'd0);
      @(negedge clk);
      cfg_we = 1'b0;
      #1 chk("prio_req_ready_high", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!resp_valid && lat < 20);
      chk("prio_latency", 32'(lat), 32'd3);
      chk("prio_result", resp_result, 32'h0000_1234);
      ack();

      // Reset while in EXEC: r1=1, r2=23 -> r22 would get 24
      @(negedge clk);
      req_valid = 1'b1;
      req_instr = rtype(5'd1, 5'd2, 5'd22, 6'h20);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mid_exec_alu_a", alu_a, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_alu_a", alu_a, 32'd0);
      chk("mid_rst_alu_b", alu_b, 32'd0);
      chk("mid_rst_alu_op", 32'(alu_op), 32'd0);
      chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
      chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("mid_rst_resp_result", resp_result, 32'd0);
      chk("mid_rst_resp_rd", 32'(resp_rd), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("mid_rel_ready_low", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("mid_rel_ready_high", 32'(req_ready), 32'd1);
      run("post_rst_regs", rtype(5'd1, 5'd2, 5'd3, 6'h20), 3, 5'd3, 32'd0, 1'b1, 1'b0, 1'b0);
      chk("post_rst_alu_a", alu_a, 32'd0);
      run("post_rst_no_wb", rtype(5'd22, 5'd0, 5'd23, 6'h25), 3, 5'd23, 32'd0, 1'b1, 1'b0,
          1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
